// File: rtl/div_share_arbiter_if.sv
// Request/response bundle between the accumulator blocks and the shared
// divider arbiter. The divider-side operand/quotient wires stay outside
// this bundle because they belong to the divider IP, not the requesters.
//
// Handshake: requester i raises req_valid[i] with stable req_numer/req_denom
// slices and holds them until it sees req_ready[i] high in the same cycle;
// the op transfers on that clock edge. req_ready is one-hot or zero and
// never high for a requester whose req_valid is low. There is no response
// backpressure: resp_valid[i] is a single-cycle pulse, and resp_quot /
// resp_zero are meaningful only in that cycle.
interface div_share_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int NUMER_W = 23,
    parameter int DENOM_W = 15,
    parameter int QUOT_W  = 11
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*NUMER_W-1:0] req_numer;
    logic [NUM_REQ*DENOM_W-1:0] req_denom;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         resp_valid;
    logic [QUOT_W-1:0]          resp_quot;
    logic                       resp_zero;

    // Requester side.
    modport master (
        output req_valid, req_numer, req_denom,
        input  req_ready, resp_valid, resp_quot, resp_zero
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_numer, req_denom,
        output req_ready, resp_valid, resp_quot, resp_zero
    );
endinterface

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one pipelined divider between NUM_REQ requesters.
// The grant is combinational; operands are registered into the divider on
// the handshake edge, and a tag pipeline carrying {valid, id, zero} follows
// the op through the divider so the quotient can be routed back.
// Zero denominators are replaced by 0/1 so the divider never sees /0.
module div_share_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int NUMER_W     = 23,
    parameter int DENOM_W     = 15,
    parameter int QUOT_W      = 11,
    parameter int DIV_LATENCY = 6
) (
    input  logic                clk,
    input  logic                rst,
    div_share_arbiter_if.slave  bus,
    output logic [NUMER_W-1:0]  div_numer,
    output logic [DENOM_W-1:0]  div_denom,
    input  logic [QUOT_W-1:0]   div_quotient,
    output logic                busy
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0] hi_mask;
    logic [NUM_REQ-1:0] masked_valid;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               hs;

    logic [NUMER_W-1:0] sel_numer;
    logic [DENOM_W-1:0] sel_denom;
    logic               sel_zero;

    logic [NUMER_W-1:0] div_numer_q, div_numer_d;
    logic [DENOM_W-1:0] div_denom_q, div_denom_d;

    // The issue stage sits alongside the operand register (cycle the divider
    // sees the operands); the DIV_LATENCY stages after it line up with the
    // cycle the divider's quotient is valid.
    logic                   iss_v_q;
    logic [ID_W-1:0]        iss_id_q;
    logic                   iss_z_q;
    logic [DIV_LATENCY-1:0] tag_v_q;
    logic [ID_W-1:0]        tag_id_q [DIV_LATENCY];
    logic [DIV_LATENCY-1:0] tag_z_q;

    logic                   last_v;
    logic [ID_W-1:0]        last_id;
    logic                   last_z;

    // Round-robin pick: first valid at or above the pointer, else wrap to
    // the lowest valid below it.
    always_comb begin
        hi_mask      = '0;
        masked_valid = '0;
        grant_id     = '0;
        hs           = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_mask[i] = (i >= int'(ptr_q));
        end
        masked_valid = bus.req_valid & hi_mask;
        if (|masked_valid) begin
            hs = 1'b1;
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (masked_valid[i]) grant_id = ID_W'(i);
            end
        end else if (|bus.req_valid) begin
            hs = 1'b1;
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (bus.req_valid[i]) grant_id = ID_W'(i);
            end
        end
        grant = hs ? (NUM_REQ'(1) << grant_id) : '0;
    end

    assign bus.req_ready = grant;

    // Pointer advances past the winner; it holds when nobody asks.
    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    // Operand mux for the winner plus zero-denominator substitution.
    always_comb begin
        sel_numer   = bus.req_numer[int'(grant_id)*NUMER_W +: NUMER_W];
        sel_denom   = bus.req_denom[int'(grant_id)*DENOM_W +: DENOM_W];
        sel_zero    = (sel_denom == '0);
        div_numer_d = div_numer_q;
        div_denom_d = div_denom_q;
        if (hs) begin
            div_numer_d = sel_zero ? '0 : sel_numer;
            div_denom_d = sel_zero ? DENOM_W'(1) : sel_denom;
        end
    end

    // Pointer and divider operand registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            div_numer_q <= '0;
            div_denom_q <= DENOM_W'(1);
        end else begin
            ptr_q       <= ptr_d;
            div_numer_q <= div_numer_d;
            div_denom_q <= div_denom_d;
        end
    end

    assign div_numer = div_numer_q;
    assign div_denom = div_denom_q;

    // Tag pipeline; reset empties it so in-flight ops never respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_v_q  <= 1'b0;
            iss_id_q <= '0;
            iss_z_q  <= 1'b0;
            tag_v_q  <= '0;
            tag_z_q  <= '0;
            for (int s = 0; s < DIV_LATENCY; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            iss_v_q     <= hs;
            iss_id_q    <= grant_id;
            iss_z_q     <= hs & sel_zero;
            tag_v_q[0]  <= iss_v_q;
            tag_id_q[0] <= iss_id_q;
            tag_z_q[0]  <= iss_z_q;
            for (int s = 1; s < DIV_LATENCY; s++) begin
                tag_v_q[s]  <= tag_v_q[s-1];
                tag_id_q[s] <= tag_id_q[s-1];
                tag_z_q[s]  <= tag_z_q[s-1];
            end
        end
    end

    // Response decode from the final tag stage, gated to zero otherwise.
    always_comb begin
        last_v         = tag_v_q[DIV_LATENCY-1];
        last_id        = tag_id_q[DIV_LATENCY-1];
        last_z         = tag_z_q[DIV_LATENCY-1];
        bus.resp_valid = last_v ? (NUM_REQ'(1) << last_id) : '0;
        bus.resp_zero  = last_v & last_z;
        bus.resp_quot  = (last_v & ~last_z) ? div_quotient : '0;
    end

    assign busy = hs | iss_v_q | (|tag_v_q);

endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Time-shares one pipelined divider IP between NUM_REQ accumulator blocks, for example several ROI centroid trackers.
- Each accumulator presents a numerator/denominator pair. The arbiter grants one per cycle, round-robin, and registers the operands into the divider.
- A tag pipeline matched to the divider latency routes each quotient back to its requester as a one-cycle response pulse.
- Zero denominators are intercepted, so the divider never sees denom=0.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
NUMER_W, 23, numerator width
DENOM_W, 15, denominator width
QUOT_W, 11, quotient width (result truncated to this)
DIV_LATENCY, 6, divider clock latency from operands-presented cycle to quotient-valid cycle (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  request pending per requester; held until granted
req_numer  in  NUM_REQ*NUMER_W  packed numerators; slice i belongs to requester i
req_denom  in  NUM_REQ*DENOM_W  packed denominators
req_ready  out  NUM_REQ  one-hot grant; handshake = req_valid[i] & req_ready[i]
div_numer  out  NUMER_W  registered numerator to divider
div_denom  out  DENOM_W  registered denominator to divider
div_quotient  in  QUOT_W  divider quotient
resp_valid  out  NUM_REQ  one-cycle pulse; bit i = response for requester i
resp_quot  out  QUOT_W  quotient, valid when any resp_valid bit is high
resp_zero  out  1  response came from a denom==0 request
busy  out  1  at least one operation in flight

Behaviour:
- Reset (async, active-high):
  - div_numer=0, div_denom=1, resp_valid=0, resp_quot=0, resp_zero=0, busy=0.
  - RR pointer=0; all tag stages invalid.
  - Reset mid-operation drops all in-flight operations: no resp_valid pulse for any operation granted before reset, even if the divider still outputs data.
- Arbitration:
  - Combinational. req_ready is one-hot or zero, and never asserts a bit whose req_valid is low.
  - Search starts at the pointer and wraps modulo NUM_REQ.
  - On a grant to i, pointer <= (i+1) mod NUM_REQ. With no request, the pointer holds.
  - One grant per cycle; the divider accepts a new operation every cycle, so there is no backpressure.
  - A requester that keeps valid high is served at least once every NUM_REQ cycles.
- Issue, on the handshake edge T:
  - div_numer<=numer and div_denom<=denom.
  - If denom==0: div_numer<=0, div_denom<=1, and the zero flag is stored in the tag.
  - With no handshake, div_numer/div_denom hold their previous values.
- Tag pipeline:
  - DIV_LATENCY stages of {valid, id (clog2(NUM_REQ), min 1 bit), zero}, loaded at edge T alongside the operands and shifted every cycle.
  - Stage output aligns with the cycle div_quotient is valid: DIV_LATENCY cycles after operands are presented, i.e. DIV_LATENCY+1 cycles after the handshake cycle.
- Response:
  - In the aligned cycle, resp_valid[id]=1 for exactly one cycle and resp_zero=zero.
  - resp_quot=div_quotient, or 0 when zero=1.
  - resp_quot and resp_zero are driven only in that cycle, else 0.
  - Back-to-back grants produce back-to-back responses in grant order.
- busy: OR of all tag valid bits, plus the current-cycle handshake.
- Width rules:
  - Quotient is taken as the divider's low QUOT_W bits; callers guarantee numer/denom < 2^QUOT_W.
  - id width is derived from NUM_REQ; unused ids are never granted.
- Simultaneous events:
  - All requesters valid in the same cycle: strictly one granted; the others keep valid high and are served in later cycles in RR order.
  - A requester may re-request in the cycle after its grant.
  - Grant and response for the same requester in the same cycle are independent.

Test Plan:
- Single request: req 0 numer=640, denom=10, one cycle at T → req_ready[0]=1 at T; div_numer=640, div_denom=10 from T+1; resp_valid[0] pulse at T+7 (DIV_LATENCY=6), resp_quot=64, resp_zero=0; busy low after T+7.
- Zero denominator: req 1 numer=500, denom=0 → divider sees 0/1; resp_valid[1] at T+7, resp_quot=0, resp_zero=1.
- Contention: both requesters hold valid from cycle 0, pointer=0 → grants alternate 0,1,0,1; responses pulse every cycle from cycle 7 with matching ids and quotients (e.g. 300/3=100 for req 0, 90/9=10 for req 1).
- Fairness/hold: req 0 held continuously, req 1 asserted at cycle 5 → req 1 granted within 2 cycles; no grant ever issued to a requester with valid low.
- Reset mid-flight: grant at T, rst pulsed at T+3 → no resp_valid through T+10; all outputs at reset values; pointer=0; a new request afterwards responds normally.
- Pipelined stream: 6 consecutive grants to req 0 with denom 1..6, numer=60 → six consecutive resp_valid[0] pulses with quotients 60, 30, 20, 15, 12, 10, in order.
